// File: rtl/ch_readout_receiver_pkg.sv
// Shared types and constants for the per-channel serial timestamp readout receiver.
package ch_readout_receiver_pkg;

    localparam int unsigned READOUT_WORD_W = 10;
    localparam int unsigned READOUT_TCNT_W = 3;
    localparam int unsigned READOUT_SEL_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        GAP
    } rx_state_t;

    typedef enum logic [2:0] {
        SEL_CA   = 3'd0,
        SEL_CB   = 3'd1,
        SEL_CC   = 3'd2,
        SEL_CD   = 3'd3,
        SEL_CE   = 3'd4,
        SEL_TCNT = 3'd5
    } rdsel_t;

    // Selects 6 and 7 have no register behind them in the channel.
    function automatic logic sel_is_reserved(input logic [READOUT_SEL_W-1:0] sel);
        return sel > SEL_TCNT;
    endfunction

endpackage

// File: rtl/ch_readout_receiver_if.sv
// Request/response bus between the global SPI controller and the readout receiver.
interface ch_readout_receiver_if
    import ch_readout_receiver_pkg::*;
#(
    parameter int unsigned WORD_W = READOUT_WORD_W
);

    logic                     rd_req;
    logic [READOUT_SEL_W-1:0] rd_sel;
    logic                     scan_req;
    logic                     abort;
    logic                     rd_ready;
    logic                     rd_valid;
    logic                     rd_err;
    logic [WORD_W-1:0]        rd_data;
    logic                     scan_done;

    modport master (
        output rd_req, rd_sel, scan_req, abort,
        input  rd_ready, rd_valid, rd_err, rd_data, scan_done
    );

    modport slave (
        input  rd_req, rd_sel, scan_req, abort,
        output rd_ready, rd_valid, rd_err, rd_data, scan_done
    );

endinterface

// File: rtl/ch_readout_shifter.sv
// Serial-in, MSB-first shift register with a bit counter that flags the last of N samples.
module ch_readout_shifter #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic [CNT_W-1:0] n_bits,
    output logic [WIDTH-1:0] data_next,
    output logic             last
);

    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;

    // Word as it will look once the current sample is taken, so the caller can capture it
    // on the same edge as the final sample.
    assign data_next = {data_q[WIDTH-2:0], ser_in};
    assign last      = shift_en && (cnt_q == n_bits - 1'b1);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clear) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_en) begin
            data_q <= data_next;
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ch_readout_receiver.sv
// Reads one counter word / trigger count from a channel, or sweeps all six into a bank.
module ch_readout_receiver
    import ch_readout_receiver_pkg::*;
#(
    parameter int unsigned WORD_W = READOUT_WORD_W,
    parameter int unsigned TCNT_W = READOUT_TCNT_W
) (
    input  logic                     SPI_CLK,
    input  logic                     RSTB,
    ch_readout_receiver_if.slave     ctrl,
    input  logic                     CNT_SER,
    output logic                     INST_READOUT,
    output logic [READOUT_SEL_W-1:0] SELECT_REG,
    output logic [WORD_W-1:0]        CA_Q,
    output logic [WORD_W-1:0]        CB_Q,
    output logic [WORD_W-1:0]        CC_Q,
    output logic [WORD_W-1:0]        CD_Q,
    output logic [WORD_W-1:0]        CE_Q,
    output logic [TCNT_W-1:0]        TRIG_CNT_Q
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    rx_state_t                state_q;
    logic                     scan_q;
    logic [READOUT_SEL_W-1:0] sel_q;
    logic                     inst_q;
    logic [READOUT_SEL_W-1:0] select_q;
    logic                     ready_q;
    logic                     valid_q;
    logic                     err_q;
    logic [WORD_W-1:0]        data_q;
    logic                     done_q;
    logic [WORD_W-1:0]        bank_q [5];
    logic [TCNT_W-1:0]        tcnt_q;

    logic                     sh_clear;
    logic                     sh_en;
    logic                     sh_last;
    logic [CNT_W-1:0]         sh_n_bits;
    logic [WORD_W-1:0]        sh_word;
    logic [WORD_W-1:0]        word;

    assign sh_clear  = (state_q == LOAD);
    assign sh_en     = (state_q == SHIFT);
    assign sh_n_bits = (sel_q == SEL_TCNT) ? CNT_W'(TCNT_W) : CNT_W'(WORD_W);
    assign word      = (sel_q == SEL_TCNT) ? WORD_W'(sh_word[TCNT_W-1:0]) : sh_word;

    ch_readout_shifter #(
        .WIDTH (WORD_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk       (SPI_CLK),
        .rstb      (RSTB),
        .clear     (sh_clear),
        .shift_en  (sh_en),
        .ser_in    (CNT_SER),
        .n_bits    (sh_n_bits),
        .data_next (sh_word),
        .last      (sh_last)
    );

    // Outputs are registered for the state being entered, so the pulses line up with DONE.
    always_ff @(posedge SPI_CLK) begin
        if (!RSTB) begin
            state_q  <= IDLE;
            scan_q   <= 1'b0;
            sel_q    <= '0;
            inst_q   <= 1'b0;
            select_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            bank_q   <= '{default: '0};
            tcnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (ctrl.abort && (state_q != IDLE)) begin
                state_q <= IDLE;
                inst_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (!ctrl.abort && ctrl.scan_req) begin
                            scan_q   <= 1'b1;
                            sel_q    <= SEL_CA;
                            select_q <= SEL_CA;
                            inst_q   <= 1'b1;
                            ready_q  <= 1'b0;
                            state_q  <= LOAD;
                        end else if (!ctrl.abort && ctrl.rd_req) begin
                            scan_q  <= 1'b0;
                            sel_q   <= ctrl.rd_sel;
                            ready_q <= 1'b0;
                            if (sel_is_reserved(ctrl.rd_sel)) begin
                                valid_q <= 1'b1;
                                err_q   <= 1'b1;
                                data_q  <= '0;
                                state_q <= DONE;
                            end else begin
                                select_q <= ctrl.rd_sel;
                                inst_q   <= 1'b1;
                                state_q  <= LOAD;
                            end
                        end
                    end
                    LOAD: begin
                        state_q <= SHIFT;
                    end
                    SHIFT: begin
                        if (sh_last) begin
                            inst_q  <= 1'b0;
                            state_q <= DONE;
                            if (scan_q) begin
                                if (sel_q == SEL_TCNT) begin
                                    tcnt_q <= word[TCNT_W-1:0];
                                    done_q <= 1'b1;
                                end else begin
                                    bank_q[sel_q] <= word;
                                end
                            end else begin
                                valid_q <= 1'b1;
                                err_q   <= 1'b0;
                                data_q  <= word;
                            end
                        end
                    end
                    DONE: begin
                        if (scan_q && (sel_q != SEL_TCNT)) begin
                            sel_q   <= sel_q + 3'd1;
                            state_q <= GAP;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    GAP: begin
                        // INST_READOUT has been low for DONE+GAP, so the channel is re-armed.
                        select_q <= sel_q;
                        inst_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                    default: begin
                        inst_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign INST_READOUT   = inst_q;
    assign SELECT_REG     = select_q;
    assign ctrl.rd_ready  = ready_q;
    assign ctrl.rd_valid  = valid_q;
    assign ctrl.rd_err    = err_q;
    assign ctrl.rd_data   = data_q;
    assign ctrl.scan_done = done_q;
    assign CA_Q           = bank_q[0];
    assign CB_Q           = bank_q[1];
    assign CC_Q           = bank_q[2];
    assign CD_Q           = bank_q[3];
    assign CE_Q           = bank_q[4];
    assign TRIG_CNT_Q     = tcnt_q;

endmodule
